// File: rtl/booth_r16_digit_encoder_if.sv
// rtl/booth_r16_digit_encoder_if.sv - Booth digit-select package and encoder handshake interface
//
// mul_pkg::booth_sel_t : magnitude of a radix-16 Booth digit, i.e. which multiple of A to pick.
// booth_r16_digit_encoder_if : operand-in / digit-out handshake bundle.
//   flush                 synchronous abort request
//   in_valid/in_ready     operand handshake, in_b carries the unsigned multiplier
//   dig_valid/dig_ready   digit handshake, dig_sel/dig_neg/dig_idx/dig_last carry the digit
//   busy                  encoder is streaming digits
//   modport slave  : the encoder side
//   modport master : the operand producer / digit consumer side

package mul_pkg;
  typedef enum logic [3:0] {
    PP_0  = 4'd0,
    PP_A  = 4'd1,
    PP_2A = 4'd2,
    PP_3A = 4'd3,
    PP_4A = 4'd4,
    PP_5A = 4'd5,
    PP_6A = 4'd6,
    PP_7A = 4'd7,
    PP_8A = 4'd8
  } booth_sel_t;
endpackage

interface booth_r16_digit_encoder_if #(
  parameter int WIDTH = 52
);
  localparam int NDIG = WIDTH / 4 + 1;
  localparam int IDXW = $clog2(NDIG);

  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    in_b;
  logic                dig_valid;
  logic                dig_ready;
  mul_pkg::booth_sel_t dig_sel;
  logic                dig_neg;
  logic [IDXW-1:0]     dig_idx;
  logic                dig_last;
  logic                busy;

  modport slave (
    input  flush, in_valid, in_b, dig_ready,
    output in_ready, dig_valid, dig_sel, dig_neg, dig_idx, dig_last, busy
  );

  modport master (
    output flush, in_valid, in_b, dig_ready,
    input  in_ready, dig_valid, dig_sel, dig_neg, dig_idx, dig_last, busy
  );
endinterface

// File: rtl/booth_r16_digit_encoder.sv
// rtl/booth_r16_digit_encoder.sv - Sequential radix-16 Booth recoder, one digit per handshake
//
// Accepts an unsigned WIDTH-bit multiplier and streams NDIG = WIDTH/4+1 Booth digits, LSB first.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    booth_r16_digit_encoder_if.slave
//          in:  flush, in_valid, in_b, dig_ready
//          out: in_ready, dig_valid, dig_sel, dig_neg, dig_idx, dig_last, busy

module booth_r16_digit_encoder #(
  parameter int WIDTH = 52
) (
  input  logic                        clk,
  input  logic                        rst_n,
  booth_r16_digit_encoder_if.slave    bus
);
  localparam int NDIG = WIDTH / 4 + 1;
  localparam int IDXW = $clog2(NDIG);
  // 4*NDIG operand bits plus the implicit b[-1] in bit 0
  localparam int SRW  = 4 * NDIG + 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [SRW-1:0]      sr;
  logic [SRW-1:0]      ld_vec;
  logic [IDXW-1:0]     idx_q;
  mul_pkg::booth_sel_t sel_q;
  logic                neg_q;
  logic                accept;
  logic                advance;
  logic                at_last;
  logic [4:0]          enc_ld;
  logic [4:0]          enc_nx;

  // Returns {neg, |d|} for a 5-bit overlapping window; a zero digit is never negative,
  // because neg is derived from the signed sum rather than from the window's top bit.
  function automatic logic [4:0] encode(input logic [4:0] w);
    int d;
    int m;
    d = -8 * int'(w[4]) + 4 * int'(w[3]) + 2 * int'(w[2]) + int'(w[1]) + int'(w[0]);
    m = (d < 0) ? -d : d;
    return {(d < 0), m[3:0]};
  endfunction

  assign ld_vec  = {{(SRW - 1 - WIDTH){1'b0}}, bus.in_b, 1'b0};
  assign accept  = (state == IDLE) && bus.in_valid && !bus.flush;
  assign advance = (state == RUN) && bus.dig_ready && !bus.flush;
  assign at_last = (idx_q == IDXW'(NDIG - 1));
  assign enc_ld  = encode(ld_vec[4:0]);
  // Window of the next digit: the register after a 4-bit right shift
  assign enc_nx  = encode(sr[8:4]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush wins over everything
  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = RUN;
        RUN:     if (advance && at_last) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.dig_valid = (state == RUN);
    bus.busy      = (state == RUN);
  end

  // Datapath: shift register, digit index and registered digit outputs.
  // On the final handshake the digit registers are left as they are; dig_valid drops anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr    <= '0;
      idx_q <= '0;
      sel_q <= mul_pkg::PP_0;
      neg_q <= 1'b0;
    end else if (bus.flush) begin
      sr    <= '0;
      idx_q <= '0;
      sel_q <= mul_pkg::PP_0;
      neg_q <= 1'b0;
    end else if (accept) begin
      sr    <= ld_vec;
      idx_q <= '0;
      sel_q <= mul_pkg::booth_sel_t'(enc_ld[3:0]);
      neg_q <= enc_ld[4];
    end else if (advance && !at_last) begin
      sr    <= sr >> 4;
      idx_q <= idx_q + 1'b1;
      sel_q <= mul_pkg::booth_sel_t'(enc_nx[3:0]);
      neg_q <= enc_nx[4];
    end
  end

  assign bus.dig_sel  = sel_q;
  assign bus.dig_neg  = neg_q;
  assign bus.dig_idx  = idx_q;
  assign bus.dig_last = at_last;

endmodule

// File: tb/tb_booth_r16_digit_encoder.sv
// tb/tb_booth_r16_digit_encoder.sv - Scoreboard testbench for booth_r16_digit_encoder

module tb_booth_r16_digit_encoder;
  localparam int WIDTH = 52;
  localparam int NDIG  = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  booth_r16_digit_encoder_if #(.WIDTH(WIDTH)) bus();

  booth_r16_digit_encoder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // mode 0: digit-exact check, 1: reconstruction only, 2: expected to be aborted
  typedef struct {
    logic [WIDTH-1:0] b;
    int               mode;
  } op_t;

  op_t        op_q[$];
  logic [4:0] dig_q[$];
  logic [3:0] exp_sel[NDIG];
  logic       exp_neg[NDIG];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < NDIG; i++) begin
      exp_sel[i] = 4'd0;
      exp_neg[i] = 1'b0;
    end
  endtask

  // Monitor / scoreboard
  bit          active = 1'b0;
  op_t         cur;
  int          cnt;
  longint      acc;

  always @(negedge clk) begin
    logic [4:0] e;
    longint     term;
    if (!rst_n || bus.flush) begin
      if (active) begin
        active = 1'b0;
        check("abort_expected", 64'(cur.mode), 64'd2);
      end
    end else if (bus.dig_valid && bus.dig_ready) begin
      if (!active) begin
        if (op_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_digit: idx %0d with no operand pending", bus.dig_idx);
        end else begin
          cur    = op_q.pop_front();
          active = 1'b1;
          cnt    = 0;
          acc    = 0;
        end
      end
      if (active) begin
        check("dig_idx", 64'(bus.dig_idx), 64'(cnt));
        check("dig_last", 64'(bus.dig_last), 64'(cnt == NDIG - 1));
        check("zero_not_neg", 64'((bus.dig_sel == mul_pkg::PP_0) && bus.dig_neg), 64'd0);
        if (cur.mode == 0) begin
          e = dig_q.pop_front();
          check("dig_sel", 64'(bus.dig_sel), 64'(e[3:0]));
          check("dig_neg", 64'(bus.dig_neg), 64'(e[4]));
        end
        term = longint'(bus.dig_sel) << (4 * cnt);
        acc  = bus.dig_neg ? acc - term : acc + term;
        cnt++;
        if (bus.dig_last) begin
          check("digit_count", 64'(cnt), 64'(NDIG));
          if (cur.mode != 2) check("reconstruct", acc, 64'(cur.b));
          active = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic [WIDTH-1:0] b, input int mode);
    logic [63:0] junk;
    for (int c = 0; c < 50 && !bus.in_ready; c++) begin
      @(posedge clk); #1;
    end
    if (!bus.in_ready) begin
      check("issue_timeout", 64'(bus.in_ready), 64'd1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_b     = b;
    op_q.push_back('{b, mode});
    if (mode == 0) begin
      for (int i = 0; i < NDIG; i++) dig_q.push_back({exp_neg[i], exp_sel[i]});
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    junk = {$urandom(), $urandom()};
    bus.in_b = junk[WIDTH-1:0];
    check("first_digit_valid", 64'(bus.dig_valid), 64'd1);
    check("first_digit_idx", 64'(bus.dig_idx), 64'd0);
    check("busy_in_run", 64'(bus.busy), 64'd1);
  endtask

  task automatic drain(input bit rnd);
    for (int c = 0; c < 400; c++) begin
      bus.dig_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (bus.dig_valid && bus.dig_ready && bus.dig_last) begin
        @(posedge clk); #1;
        check("in_ready_after_last", 64'(bus.in_ready), 64'd1);
        check("valid_after_last", 64'(bus.dig_valid), 64'd0);
        bus.dig_ready = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    check("drain_timeout", 64'(bus.busy), 64'd0);
    bus.dig_ready = 1'b1;
  endtask

  task automatic wait_idx(input int target);
    for (int c = 0; c < 40 && !(bus.dig_valid && bus.dig_idx == target); c++) begin
      @(posedge clk); #1;
    end
    check("reach_idx", 64'(bus.dig_idx), 64'(target));
  endtask

  task automatic issue_eight();
    clear_exp();
    exp_sel[0] = 4'd8; exp_neg[0] = 1'b1;
    exp_sel[1] = 4'd1;
    issue(52'h8, 0);
    drain(1'b0);
  endtask

  initial begin
    logic [63:0] r;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_b      = '0;
    bus.dig_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_dig_valid", 64'(bus.dig_valid), 64'd0);
    check("rst_dig_sel", 64'(bus.dig_sel), 64'd0);
    check("rst_dig_neg", 64'(bus.dig_neg), 64'd0);
    check("rst_dig_idx", 64'(bus.dig_idx), 64'd0);
    check("rst_dig_last", 64'(bus.dig_last), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero operand: all PP_0
    clear_exp();
    issue(52'h0, 0);
    drain(1'b0);

    // b = 1
    clear_exp();
    exp_sel[0] = 4'd1;
    issue(52'h1, 0);
    drain(1'b0);

    // b = 8: -8 + 16
    issue_eight();

    // b = 0xF: -1 + 16
    clear_exp();
    exp_sel[0] = 4'd1; exp_neg[0] = 1'b1;
    exp_sel[1] = 4'd1;
    issue(52'hF, 0);
    drain(1'b0);

    // All ones: -1 + 16^13
    clear_exp();
    exp_sel[0]  = 4'd1; exp_neg[0] = 1'b1;
    exp_sel[13] = 4'd1;
    issue({WIDTH{1'b1}}, 0);
    drain(1'b0);

    // Backpressure at idx 1 on 0x123: digits +3, +2, +1
    clear_exp();
    exp_sel[0] = 4'd3;
    exp_sel[1] = 4'd2;
    exp_sel[2] = 4'd1;
    issue(52'h123, 0);
    wait_idx(1);
    bus.dig_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("bp_valid", 64'(bus.dig_valid), 64'd1);
      check("bp_sel", 64'(bus.dig_sel), 64'd2);
      check("bp_neg", 64'(bus.dig_neg), 64'd0);
      check("bp_idx", 64'(bus.dig_idx), 64'd1);
    end
    drain(1'b0);

    // flush together with in_valid in IDLE: operand not accepted
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_b     = 52'h5;
    @(posedge clk); #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_idle_busy", 64'(bus.busy), 64'd0);
    check("flush_idle_ready", 64'(bus.in_ready), 64'd1);
    check("flush_idle_valid", 64'(bus.dig_valid), 64'd0);

    // flush mid-stream at idx 5
    issue(52'h1_2345_6789_ABCD, 2);
    wait_idx(5);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_valid", 64'(bus.dig_valid), 64'd0);
    check("flush_busy", 64'(bus.busy), 64'd0);
    check("flush_ready", 64'(bus.in_ready), 64'd1);
    check("flush_idx", 64'(bus.dig_idx), 64'd0);
    check("flush_sel", 64'(bus.dig_sel), 64'd0);
    check("flush_neg", 64'(bus.dig_neg), 64'd0);
    check("flush_last", 64'(bus.dig_last), 64'd0);
    issue_eight();

    // Asynchronous reset mid-stream at idx 7
    issue(52'hF_EDCB_A987_6543, 2);
    wait_idx(7);
    rst_n = 1'b0;
    #1;
    check("areset_valid", 64'(bus.dig_valid), 64'd0);
    check("areset_busy", 64'(bus.busy), 64'd0);
    check("areset_ready", 64'(bus.in_ready), 64'd1);
    check("areset_idx", 64'(bus.dig_idx), 64'd0);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue_eight();

    // Random operands with random backpressure
    for (int n = 0; n < 1500; n++) begin
      r = {$urandom(), $urandom()};
      issue(r[WIDTH-1:0], 1);
      drain(1'b1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("op_q_empty", 64'(op_q.size()), 64'd0);
    check("dig_q_empty", 64'(dig_q.size()), 64'd0);
    check("monitor_idle", 64'(active), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
